// File: rtl/tank_pkg.sv
// Shared screen geometry, coordinate/step types and bullet defaults for the tank game.
package tank_pkg;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int LIFETIME_DEF = 300;
  localparam int COOLDOWN_DEF = 35;

  typedef logic [9:0]         coord_t;
  typedef logic signed [10:0] step_t;

  // Heading component (64 = 1.0) to per-frame pixel step: sign-extend, then divide by 16.
  function automatic step_t trig_step(input logic [7:0] v);
    step_t s;
    s = step_t'({{3{v[7]}}, v});
    return s >>> 4;
  endfunction
endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position, step, age, expiry and move. Wall hits bounce when
// BULLET_BOUNCE_EN is defined, otherwise they kill the bullet.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = LIFETIME_DEF
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   tick,
  input  logic   clear_all,
  input  logic   spawn,
  input  logic   hit,
  input  logic   wall_x,
  input  logic   wall_y,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  input  step_t  spawn_sx,
  input  step_t  spawn_sy,
  output coord_t x,
  output coord_t y,
  output logic   active,
  output logic   free
);
  localparam int AW = (LIFETIME > 2) ? $clog2(LIFETIME) : 1;
  localparam logic [AW-1:0] AGE_LAST = AW'(LIFETIME - 1);

  step_t sx, sy, bsx, bsy, nx, ny;
  logic [AW-1:0] age;
  logic die;

  always_comb begin
    bsx = sx;
    bsy = sy;
    die = 1'b0;
`ifdef BULLET_BOUNCE_EN
    if (wall_x) bsx = -sx;
    if (wall_y) bsy = -sy;
`else
    die = wall_x | wall_y;
`endif
    nx = step_t'({1'b0, x}) + bsx;
    ny = step_t'({1'b0, y}) + bsy;
    if (age == AGE_LAST || nx[10] || ny[10] ||
        nx >= step_t'(SCREEN_W) || ny >= step_t'(SCREEN_H))
      die = 1'b1;
    // A slot expiring on this tick is reusable by the same tick's spawn; a hit slot never is.
    free = ~hit & (~active | (tick & die));
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      x      <= '0;
      y      <= '0;
      sx     <= '0;
      sy     <= '0;
      age    <= '0;
      active <= 1'b0;
    end else if (clear_all | hit) begin
      active <= 1'b0;
    end else if (tick) begin
      if (active) begin
        if (die) active <= 1'b0;
        else begin
          x   <= nx[9:0];
          y   <= ny[9:0];
          sx  <= bsx;
          sy  <= bsy;
          age <= age + 1'b1;
        end
      end
      if (spawn) begin
        x      <= spawn_x;
        y      <= spawn_y;
        sx     <= spawn_sx;
        sy     <= spawn_sy;
        age    <= '0;
        active <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: frame tick and fire edge detection, cooldown and lowest-free-slot
// allocation over NUM_BULLETS bullet_slot instances. Wall bounce via BULLET_BOUNCE_EN.
module bullet_pool
  import tank_pkg::*;
#(
  parameter int NUM_BULLETS = 3,
  parameter int LIFETIME    = LIFETIME_DEF,
  parameter int COOLDOWN    = COOLDOWN_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     vs,
  input  logic                     fire,
  input  logic                     clear_all,
  input  logic [9:0]               tank_x,
  input  logic [9:0]               tank_y,
  input  logic [7:0]               sin,
  input  logic [7:0]               cos,
  input  logic [NUM_BULLETS-1:0]   wall_x_hit,
  input  logic [NUM_BULLETS-1:0]   wall_y_hit,
  input  logic [NUM_BULLETS-1:0]   tank_hit,
  output logic [10*NUM_BULLETS-1:0] bullet_x,
  output logic [10*NUM_BULLETS-1:0] bullet_y,
  output logic [NUM_BULLETS-1:0]   bullet_active,
  output logic                     spawned
);
  localparam int CW = $clog2(COOLDOWN + 1);

  logic vs_q, fire_q, tick, pending, do_spawn;
  logic [CW-1:0] cooldown;
  logic [NUM_BULLETS-1:0] free, grant;
  step_t step_x, step_y;

  assign step_x = trig_step(cos);
  assign step_y = trig_step(sin);

  always_comb begin
    grant = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (free[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    do_spawn = tick & pending & (cooldown == '0) & (|free) & ~clear_all;
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
      .CLK      (CLK),
      .RESET    (RESET),
      .tick     (tick),
      .clear_all(clear_all),
      .spawn    (do_spawn & grant[i]),
      .hit      (tank_hit[i]),
      .wall_x   (wall_x_hit[i]),
      .wall_y   (wall_y_hit[i]),
      .spawn_x  (tank_x),
      .spawn_y  (tank_y),
      .spawn_sx (step_x),
      .spawn_sy (step_y),
      .x        (bullet_x[10*i +: 10]),
      .y        (bullet_y[10*i +: 10]),
      .active   (bullet_active[i]),
      .free     (free[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vs_q     <= 1'b0;
      fire_q   <= 1'b0;
      tick     <= 1'b0;
      pending  <= 1'b0;
      cooldown <= '0;
      spawned  <= 1'b0;
    end else begin
      vs_q    <= vs;
      fire_q  <= fire;
      tick    <= vs_q & ~vs;
      spawned <= do_spawn;
      if (clear_all) begin
        pending  <= 1'b0;
        cooldown <= '0;
      end else if (tick) begin
        // Requests never carry past a frame: a blocked shot is simply lost.
        pending <= 1'b0;
        if (do_spawn)             cooldown <= CW'(COOLDOWN);
        else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
      end else if (fire & ~fire_q) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus random stimulus
// against a frame-level reference model of the bullet rules.
module tb_bullet_pool;
  localparam int N  = 3;
  localparam int LT = 300;
  localparam int CD = 35;

  logic CLK = 1'b0, RESET = 1'b0, vs = 1'b0, fire = 1'b0, clear_all = 1'b0;
  logic [9:0] tank_x = '0, tank_y = '0;
  logic [7:0] sin = '0, cos = '0;
  logic [N-1:0] wall_x_hit = '0, wall_y_hit = '0, tank_hit = '0;
  logic [10*N-1:0] bullet_x, bullet_y;
  logic [N-1:0] bullet_active;
  logic spawned;

  bullet_pool #(.NUM_BULLETS(N), .LIFETIME(LT), .COOLDOWN(CD)) dut (
    .CLK(CLK), .RESET(RESET), .vs(vs), .fire(fire), .clear_all(clear_all),
    .tank_x(tank_x), .tank_y(tank_y), .sin(sin), .cos(cos),
    .wall_x_hit(wall_x_hit), .wall_y_hit(wall_y_hit), .tank_hit(tank_hit),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .spawned(spawned)
  );

  always #10 CLK = ~CLK;

  int n_tests = 0, n_fail = 0, n_spawn = 0;

  // Reference state in plain integers
  int m_x[N], m_y[N], m_sx[N], m_sy[N], m_age[N];
  bit m_act[N];
  bit m_pend, m_vs, m_fire, m_tick, m_spawned;
  int m_cd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int step_of(input logic [7:0] v);
    int s;
    s = $signed(v);
    if (s >= 0) return s / 16;
    return -((-s + 15) / 16);
  endfunction

  task automatic model_step();
    bit tk, pend_old, rise, die, found;
    int cd_old, sx, sy, nx, ny;
    if (!RESET) begin
      for (int i = 0; i < N; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_age[i] = 0; m_act[i] = 0;
      end
      m_pend = 0; m_vs = 0; m_fire = 0; m_tick = 0; m_spawned = 0; m_cd = 0;
      return;
    end
    tk = m_tick; pend_old = m_pend; cd_old = m_cd;
    m_tick = m_vs && !vs;
    m_vs = vs;
    rise = fire && !m_fire;
    m_fire = fire;
    m_spawned = 0;
    if (clear_all) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
      m_pend = 0; m_cd = 0;
      return;
    end
    if (tk) begin
      for (int i = 0; i < N; i++) begin
        if (m_act[i] && !tank_hit[i]) begin
          sx = m_sx[i]; sy = m_sy[i]; die = 0;
`ifdef BULLET_BOUNCE_EN
          if (wall_x_hit[i]) sx = -sx;
          if (wall_y_hit[i]) sy = -sy;
`else
          if (wall_x_hit[i] || wall_y_hit[i]) die = 1;
`endif
          nx = m_x[i] + sx; ny = m_y[i] + sy;
          if (m_age[i] == LT - 1 || nx < 0 || nx > 639 || ny < 0 || ny > 479) die = 1;
          if (die) m_act[i] = 0;
          else begin
            m_x[i] = nx; m_y[i] = ny; m_sx[i] = sx; m_sy[i] = sy; m_age[i]++;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) if (tank_hit[i]) m_act[i] = 0;
    found = 0;
    if (tk && pend_old && cd_old == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!found && !m_act[i] && !tank_hit[i]) begin
          found = 1;
          m_act[i] = 1; m_x[i] = tank_x; m_y[i] = tank_y;
          m_sx[i] = step_of(cos); m_sy[i] = step_of(sin); m_age[i] = 0;
        end
      end
    end
    m_spawned = found;
    if (tk) begin
      m_pend = 0;
      if (found) m_cd = CD;
      else if (cd_old > 0) m_cd = cd_old - 1;
    end else if (rise) m_pend = 1;
  endtask

  task automatic cyc();
    logic [63:0] ea, ex, ey;
    @(posedge CLK);
    model_step();
    #1;
    if (spawned) n_spawn++;
    ea = '0; ex = '0; ey = '0;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_act[i];
      ex = ex | (64'(m_x[i]) << (10 * i));
      ey = ey | (64'(m_y[i]) << (10 * i));
    end
    chk("active", 64'(bullet_active), ea);
    chk("spawned", 64'(spawned), 64'(m_spawned));
    chk("pos_x", 64'(bullet_x), ex);
    chk("pos_y", 64'(bullet_y), ey);
  endtask

  // Five-cycle frame: the tick is processed on the fourth edge, where th/clr/wx apply.
  task automatic frame(input bit f, input logic [N-1:0] th, input bit clr, input logic [N-1:0] wx);
    fire = 1'b0; vs = 1'b1; cyc();
    fire = f; cyc();
    vs = 1'b0; cyc();
    tank_hit = th; clear_all = clr; wall_x_hit = wx; cyc();
    tank_hit = '0; clear_all = 1'b0; wall_x_hit = '0; cyc();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) frame(1'b0, '0, 1'b0, '0);
  endtask

  task automatic clr();
    clear_all = 1'b1; cyc(); clear_all = 1'b0;
  endtask

  int s0;
  int per;

  initial begin
    RESET = 1'b0;
    cyc(); cyc();
    chk("rst_active", 64'(bullet_active), 64'd0);
    chk("rst_x", 64'(bullet_x), 64'd0);
    chk("rst_spawned", 64'(spawned), 64'd0);
    RESET = 1'b1;

    // Fire, spawn at tank position, then one move of +4
    tank_x = 10'd320; tank_y = 10'd240; cos = 8'd64; sin = 8'd0;
    idle(1);
    s0 = n_spawn;
    frame(1'b1, '0, 1'b0, '0);
    chk("fire_act", 64'(bullet_active), 64'b001);
    chk("fire_x", 64'(bullet_x[9:0]), 64'd320);
    chk("fire_y", 64'(bullet_y[9:0]), 64'd240);
    idle(1);
    chk("move_x", 64'(bullet_x[9:0]), 64'd324);
    chk("spawn_once", 64'(n_spawn - s0), 64'd1);

    // Cooldown and allocation: fires on frames 0, 10, 40
    clr();
    s0 = n_spawn;
    frame(1'b1, '0, 1'b0, '0);
    idle(9);
    frame(1'b1, '0, 1'b0, '0);
    chk("cd_drop", 64'(bullet_active), 64'b001);
    idle(29);
    frame(1'b1, '0, 1'b0, '0);
    chk("alloc_slot1", 64'(bullet_active), 64'b011);
    chk("cd_spawns", 64'(n_spawn - s0), 64'd2);

    // Wall contact on a tick with step +4
    clr();
    frame(1'b1, '0, 1'b0, '0);
    frame(1'b0, '0, 1'b0, 3'b001);
`ifdef BULLET_BOUNCE_EN
    chk("wall_bounce_x", 64'(bullet_x[9:0]), 64'd316);
    chk("wall_bounce_act", 64'(bullet_active[0]), 64'd1);
`else
    chk("wall_kill", 64'(bullet_active[0]), 64'd0);
`endif

    // Right-edge boundary
    clr();
    tank_x = 10'd638;
    frame(1'b1, '0, 1'b0, '0);
    chk("edge_spawn", 64'(bullet_active[0]), 64'd1);
    idle(1);
    chk("edge_kill", 64'(bullet_active[0]), 64'd0);

    // Lifetime with zero step
    clr();
    tank_x = 10'd320; cos = 8'd0; sin = 8'd0;
    frame(1'b1, '0, 1'b0, '0);
    idle(LT - 1);
    chk("life_299", 64'(bullet_active[0]), 64'd1);
    idle(1);
    chk("life_300", 64'(bullet_active[0]), 64'd0);

    // Saturation: all slots busy, then a freed slot must not pick up the dropped request
    clr();
    frame(1'b1, '0, 1'b0, '0); idle(39);
    frame(1'b1, '0, 1'b0, '0); idle(39);
    frame(1'b1, '0, 1'b0, '0);
    chk("sat_full", 64'(bullet_active), 64'b111);
    idle(39);
    s0 = n_spawn;
    frame(1'b1, '0, 1'b0, '0);
    chk("sat_nospawn", 64'(n_spawn - s0), 64'd0);
    frame(1'b0, 3'b001, 1'b0, '0);
    chk("sat_pend_clear", 64'(bullet_active), 64'b110);
    chk("sat_nospawn2", 64'(n_spawn - s0), 64'd0);

    // tank_hit on a tick: no move on the hit slot
    clr();
    tank_x = 10'd100; cos = 8'd16;
    frame(1'b1, '0, 1'b0, '0); idle(39);
    frame(1'b1, '0, 1'b0, '0);
    chk("two_live", 64'(bullet_active), 64'b011);
    frame(1'b0, 3'b010, 1'b0, '0);
    chk("hit_kill", 64'(bullet_active), 64'b001);
    chk("hit_nomove", 64'(bullet_x[19:10]), 64'd100);
    chk("hit_other_moves", 64'(bullet_x[9:0]), 64'd141);

    // clear_all on a spawn-eligible tick
    clr();
    s0 = n_spawn;
    frame(1'b1, '0, 1'b1, '0);
    chk("clr_act", 64'(bullet_active), 64'd0);
    chk("clr_nospawn", 64'(n_spawn - s0), 64'd0);

    // Reset mid-flight discards a pending request
    frame(1'b1, '0, 1'b0, '0);
    chk("pre_rst_act", 64'(bullet_active), 64'b001);
    fire = 1'b0; cyc(); fire = 1'b1; cyc();
    RESET = 1'b0; cyc(); RESET = 1'b1;
    chk("rst_kill", 64'(bullet_active), 64'd0);
    s0 = n_spawn;
    idle(1);
    chk("rst_nospawn", 64'(n_spawn - s0), 64'd0);

    // Random stimulus against the model
    per = 0;
    for (int c = 0; c < 12000; c++) begin
      if (per == 0) begin
        vs = ~vs;
        per = $urandom_range(1, 5);
      end else per--;
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      tank_x = 10'($urandom_range(0, 639));
      tank_y = 10'($urandom_range(0, 479));
      cos = 8'($urandom);
      sin = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        wall_x_hit[i] = ($urandom_range(0, 15) == 0);
        wall_y_hit[i] = ($urandom_range(0, 15) == 0);
        tank_hit[i]   = ($urandom_range(0, 63) == 0);
      end
      clear_all = ($urandom_range(0, 799) == 0);
      RESET = ($urandom_range(0, 1999) != 0);
      cyc();
    end
    RESET = 1'b1; clear_all = 1'b0; tank_hit = '0; wall_x_hit = '0; wall_y_hit = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameters SHALL be: NUM_BULLETS, default 3, number of bullet slots; LIFETIME, default 300, bullet life in frames; COOLDOWN, default 35, minimum frames between spawns.
REQ-002 Ports SHALL be, in order:
- CLK, in, 1, 50 MHz clock.
- RESET, in, 1, reset; the only clock is CLK, reset is synchronous and active-low.
- vs, in, 1, VGA vertical sync.
- fire, in, 1, level shoot request from the tank.
- clear_all, in, 1, round restart from the game state machine.
- tank_x, in, 10, tank centre X.
- tank_y, in, 10, tank centre Y.
- sin, in, 8, signed heading sine, 64 = 1.0.
- cos, in, 8, signed heading cosine, 64 = 1.0.
- wall_x_hit, in, NUM_BULLETS, per-slot vertical-wall contact.
- wall_y_hit, in, NUM_BULLETS, per-slot horizontal-wall contact.
- tank_hit, in, NUM_BULLETS, per-slot tank contact.
- bullet_x, out, 10*NUM_BULLETS, slot X, packed with slot 0 in the LSBs.
- bullet_y, out, 10*NUM_BULLETS, slot Y, packed with slot 0 in the LSBs.
- bullet_active, out, NUM_BULLETS, slot live.
- spawned, out, 1, one-cycle pulse on a spawn.

Function
REQ-003 A frame tick SHALL be a one-cycle internal pulse asserted the CLK cycle after vs is sampled going 1->0.
REQ-004 A 0->1 edge of fire, sampled on CLK, SHALL set pending; further edges while pending is set SHALL have no extra effect.
REQ-005 On a frame tick, slots SHALL be processed in this order: expire, move, then spawn.
REQ-006 Expire SHALL clear a slot whose age reaches LIFETIME-1, or whose next position would leave X 0..639 or Y 0..479.
REQ-007 Move SHALL be x += sext(cos)>>>4 and y += sext(sin)>>>4, using per-slot step registers latched at spawn; the arithmetic SHALL be 11-bit signed and truncated to 10 bits after the bounds check.
REQ-008 Spawn SHALL occur when pending=1, cooldown=0 and a free slot exists.
REQ-009 On spawn, the lowest-index free slot SHALL load tank_x/tank_y, the steps and age 0; cooldown SHALL load COOLDOWN; spawned SHALL pulse.
REQ-010 pending SHALL clear on every frame tick, whether or not a spawn happened; when all slots are busy the request SHALL be dropped.
REQ-011 cooldown SHALL decrement by 1 per frame tick and saturate at 0.
REQ-012 A tank_hit bit SHALL clear its slot on the next CLK edge regardless of the frame tick; tank_hit SHALL win over a simultaneous move or spawn on that slot.
REQ-013 clear_all SHALL deactivate all slots and zero pending and cooldown in one cycle; it SHALL take priority over all other events.
REQ-014 All outputs SHALL be registered; a new spawn or move SHALL be visible on outputs one CLK after the frame tick.
REQ-015 Positions of inactive slots SHALL hold their last value; consumers SHALL gate on bullet_active.

Reset
REQ-016 With RESET=0 at a CLK edge, bullet_active=0, bullet_x=0, bullet_y=0, spawned=0, and pending, cooldown, ages, steps and the vs/fire edge registers SHALL all be 0.
REQ-017 A reset mid-flight SHALL kill all bullets; the first frame tick after reset release SHALL NOT spawn, because pending is cleared.

Configuration
REQ-018 With BULLET_BOUNCE_EN defined, wall_x_hit SHALL negate the X step and wall_y_hit SHALL negate the Y step before that frame's move, and both SHALL negate together.
REQ-019 Without BULLET_BOUNCE_EN, any wall hit on a frame tick SHALL clear the slot instead.

Structure
REQ-020 Package tank_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, the coord_t typedef (10-bit), the step_t typedef (signed 11-bit) and the default LIFETIME/COOLDOWN constants.
REQ-021 Per-slot state SHALL live in sub-module bullet_slot, instantiated NUM_BULLETS times; allocation, cooldown and edge detection SHALL stay in bullet_pool.

Verification
REQ-022 Fire test: fire rises; tank (320,240); cos=64, sin=0; frame tick -> slot0 active at (320,240); next tick -> (324,240); spawned pulses once.
REQ-023 Cooldown/allocation test: fire on frames 0, 10 and 40 -> spawn at 0, drop at 10, slot1 at 40.
REQ-024 Saturation test: all 3 slots busy, fire with cooldown 0 -> no spawn, and pending is clear after the tick.
REQ-025 Wall test: wall_x_hit[0] on a tick with step +4 -> X moves -4 with BULLET_BOUNCE_EN defined; slot0 inactive without it.
REQ-026 Boundary/lifetime test: bullet at X=638 with step +4 -> inactive after the tick; a bullet left alone -> inactive after exactly 300 ticks.
REQ-027 Priority test: tank_hit[1] coincident with a tick -> slot1 inactive with no move; clear_all during a spawn tick -> all inactive and spawned=0.
